// File: rtl/niosii_ocimem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : niosii_ocimem_access_ctrl
// Description : Turns debug-slave JTAG strobes into word reads/writes on the
//               OCI debug memory and returns MonDReg/ready/error status.
//               Optional stall timeout: define OCIMEM_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module niosii_ocimem_access_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_INC  = 2'd3
    } state_t;

    state_t r_state;

    // The stall counter is 8 bits wide, so only 1..255 are meaningful.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_timeout_cyc_out_of_range
    end

    logic w_any_strobe;
    logic w_multi_strobe;
    logic w_unused;

    assign w_any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign w_multi_strobe = (take_action_ocimem_a & take_no_action_ocimem_a)
                          | (take_action_ocimem_a & take_action_ocimem_b)
                          | (take_no_action_ocimem_a & take_action_ocimem_b);
    assign w_unused       = ^{jdo[37], jdo[1:0]};

`ifdef OCIMEM_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYC);
    logic [7:0] r_stall_cnt;
    logic [7:0] w_stall_next;
    assign w_stall_next = r_stall_cnt + 8'd1;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            mem_address   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
`ifdef OCIMEM_TIMEOUT_EN
            r_stall_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef OCIMEM_TIMEOUT_EN
                    r_stall_cnt <= '0;
`endif
                    if (take_action_ocimem_a) begin
                        mem_address <= jdo[ADDR_W+1:2];
                        if (jdo[36]) begin
                            monitor_error <= 1'b0;
                        end
                        if (jdo[35]) begin
                            r_state       <= S_RD;
                            mem_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        mem_address   <= mem_address + 1'b1;
                        r_state       <= S_RD;
                        mem_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                    end else if (take_action_ocimem_b) begin
                        mem_writedata <= jdo[34:3];
                        MonDReg       <= jdo[34:3];
                        r_state       <= S_WR;
                        mem_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                    end
                    // Losing strobes are dropped; flag set after any clear above.
                    if (w_multi_strobe) begin
                        monitor_error <= 1'b1;
                    end
                end
                S_RD: begin
                    if (!mem_waitrequest) begin
                        MonDReg       <= mem_readdata;
                        mem_read      <= 1'b0;
                        monitor_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end
`ifdef OCIMEM_TIMEOUT_EN
                    else if (w_stall_next == c_TIMEOUT) begin
                        mem_read      <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_stall_cnt <= w_stall_next;
                    end
`endif
                end
                S_WR: begin
                    if (!mem_waitrequest) begin
                        mem_write <= 1'b0;
                        r_state   <= S_INC;
                    end
`ifdef OCIMEM_TIMEOUT_EN
                    else if (w_stall_next == c_TIMEOUT) begin
                        mem_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_stall_cnt <= w_stall_next;
                    end
`endif
                end
                S_INC: begin
                    mem_address   <= mem_address + 1'b1;
                    monitor_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (r_state != S_IDLE && w_any_strobe) begin
                monitor_error <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
